iob_pfsm_timed: RTL

- Programmable finite state machine (PFSM) with a per-transition dwell timer, a run/halt/single-step controller, a state breakpoint and a transition counter.
- Next state, outputs and dwell count all come from a software-loaded LUT, addressed by {current_state, input_i}.
- Sits behind the core's software-register block: the register file drives the control and LUT-write ports; status outputs feed its read registers.

---
 rtl/iob_pfsm_timed_pkg.sv | 42 ++++
 rtl/iob_pfsm_timed_if.sv | 44 ++++
 rtl/iob_pfsm_timed_lut.sv | 27 ++
 rtl/iob_pfsm_timed.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/iob_pfsm_timed_pkg.sv
// rtl/iob_pfsm_timed_pkg.sv - shared widths, LUT field offsets and controller encodings
package iob_pfsm_timed_pkg;

    // Default configuration, used as parameter defaults by every file of the block
    localparam int DEF_STATE_W  = 2;
    localparam int DEF_INPUT_W  = 1;
    localparam int DEF_OUTPUT_W = 1;
    localparam int DEF_DWELL_W  = 8;
    localparam int DEF_CNT_W    = 16;

    // Derived LUT geometry for the default configuration
    localparam int LUT_ADDR_W = DEF_STATE_W + DEF_INPUT_W;
    localparam int LUT_DATA_W = DEF_DWELL_W + DEF_STATE_W + DEF_OUTPUT_W;

    // LUT word layout {dwell, next_state, output}, output in the LSBs
    localparam int OUT_LSB   = 0;
    localparam int NXT_LSB   = DEF_OUTPUT_W;
    localparam int DWELL_LSB = DEF_OUTPUT_W + DEF_STATE_W;

    typedef enum logic {
        HALT = 1'b0,
        RUN  = 1'b1
    } ctrl_e;

    // Same derivations for a non-default parameter set
    function automatic int lut_addr_w(input int state_w, input int input_w);
        return state_w + input_w;
    endfunction

    function automatic int lut_data_w(input int dwell_w, input int state_w, input int output_w);
        return dwell_w + state_w + output_w;
    endfunction

    function automatic int nxt_lsb(input int output_w);
        return OUT_LSB + output_w;
    endfunction

    function automatic int dwell_lsb(input int output_w, input int state_w);
        return OUT_LSB + output_w + state_w;
    endfunction

endpackage

// File: rtl/iob_pfsm_timed_if.sv
// rtl/iob_pfsm_timed_if.sv - register-block side of the PFSM: control, LUT write and status
interface iob_pfsm_timed_if #(
    parameter int STATE_W = iob_pfsm_timed_pkg::DEF_STATE_W,
    parameter int INPUT_W = iob_pfsm_timed_pkg::DEF_INPUT_W,
    parameter int OUTPUT_W = iob_pfsm_timed_pkg::DEF_OUTPUT_W,
    parameter int DWELL_W = iob_pfsm_timed_pkg::DEF_DWELL_W,
    parameter int CNT_W   = iob_pfsm_timed_pkg::DEF_CNT_W
);
    import iob_pfsm_timed_pkg::*;

    localparam int ADDR_W = lut_addr_w(STATE_W, INPUT_W);
    localparam int DATA_W = lut_data_w(DWELL_W, STATE_W, OUTPUT_W);

    // Control driven by the register file
    logic               softreset_i;
    logic               run_i;
    logic               step_i;
    logic               bkpt_en_i;
    logic [STATE_W-1:0] bkpt_state_i;
    logic               bkpt_clr_i;
    logic               lut_we_i;
    logic [ADDR_W-1:0]  lut_addr_i;
    logic [DATA_W-1:0]  lut_wdata_i;

    // Status read back by the register file
    logic [STATE_W-1:0] state_o;
    logic [DWELL_W-1:0] dwell_o;
    logic               running_o;
    logic               bkpt_hit_o;
    logic [CNT_W-1:0]   trans_cnt_o;

    modport master (
        output softreset_i, run_i, step_i, bkpt_en_i, bkpt_state_i, bkpt_clr_i,
               lut_we_i, lut_addr_i, lut_wdata_i,
        input  state_o, dwell_o, running_o, bkpt_hit_o, trans_cnt_o
    );

    modport slave (
        input  softreset_i, run_i, step_i, bkpt_en_i, bkpt_state_i, bkpt_clr_i,
               lut_we_i, lut_addr_i, lut_wdata_i,
        output state_o, dwell_o, running_o, bkpt_hit_o, trans_cnt_o
    );

endinterface

// File: rtl/iob_pfsm_timed_lut.sv
// rtl/iob_pfsm_timed_lut.sv - transition LUT: one synchronous write port, one asynchronous read port
module iob_pfsm_timed_lut
    import iob_pfsm_timed_pkg::*;
#(
    parameter int ADDR_W = LUT_ADDR_W,
    parameter int DATA_W = LUT_DATA_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Write lands on the edge, so a same-cycle read still returns the old word
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/iob_pfsm_timed.sv
// rtl/iob_pfsm_timed.sv - LUT-programmed FSM with dwell timer, run/halt/step controller and breakpoint
module iob_pfsm_timed
    import iob_pfsm_timed_pkg::*;
#(
    parameter int STATE_W  = DEF_STATE_W,
    parameter int INPUT_W  = DEF_INPUT_W,
    parameter int OUTPUT_W = DEF_OUTPUT_W,
    parameter int DWELL_W  = DEF_DWELL_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                arst_i,
    iob_pfsm_timed_if.slave     regs_if,
    input  logic [INPUT_W-1:0]  input_i,
    output logic [OUTPUT_W-1:0] output_o
);

    localparam int ADDR_W   = lut_addr_w(STATE_W, INPUT_W);
    localparam int DATA_W   = lut_data_w(DWELL_W, STATE_W, OUTPUT_W);
    localparam int N_LSB    = nxt_lsb(OUTPUT_W);
    localparam int D_LSB    = dwell_lsb(OUTPUT_W, STATE_W);

    ctrl_e               ctrl_q, ctrl_d;
    logic [STATE_W-1:0]  state_q, state_d;
    logic [OUTPUT_W-1:0] out_q, out_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                hit_q, hit_d;

    logic [DATA_W-1:0]   lut_word;
    logic [STATE_W-1:0]  lut_nxt;
    logic [OUTPUT_W-1:0] lut_out;
    logic [DWELL_W-1:0]  lut_dwell;
    logic                lut_wr;
    logic                tick;
    logic                trans;
    logic                bkpt_event;

    assign lut_out   = lut_word[OUT_LSB +: OUTPUT_W];
    assign lut_nxt   = lut_word[N_LSB +: STATE_W];
    assign lut_dwell = lut_word[D_LSB +: DWELL_W];

    // Soft reset outranks a LUT write in the same cycle; a frozen clock enable blocks it too
    assign lut_wr = cke_i & regs_if.lut_we_i & ~regs_if.softreset_i;

    iob_pfsm_timed_lut #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_lut (
        .clk_i   (clk_i),
        .we_i    (lut_wr),
        .waddr_i (regs_if.lut_addr_i),
        .wdata_i (regs_if.lut_wdata_i),
        .raddr_i ({state_q, input_i}),
        .rdata_o (lut_word)
    );

    // Controller state register; soft reset and clock enable act synchronously
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ctrl_q <= HALT;
        end else if (cke_i) begin
            ctrl_q <= regs_if.softreset_i ? HALT : ctrl_d;
        end
    end

    // Controller next state: a breakpoint hit always lands in HALT
    always_comb begin
        ctrl_d = ctrl_q;
        case (ctrl_q)
            HALT:    if (regs_if.run_i && !hit_q) ctrl_d = RUN;
            RUN:     if (!regs_if.run_i) ctrl_d = HALT;
            default: ctrl_d = HALT;
        endcase
        if (bkpt_event) begin
            ctrl_d = HALT;
        end
    end

    // Controller outputs: tick enable, transition qualifier and breakpoint detect
    always_comb begin
        tick       = (ctrl_q == RUN) ? regs_if.run_i : regs_if.step_i;
        trans      = tick && (dwell_q == '0);
        bkpt_event = trans && regs_if.bkpt_en_i && (lut_nxt == regs_if.bkpt_state_i);
    end

    // Datapath next state: transition loads the LUT word, otherwise a tick burns one dwell count
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        if (trans) begin
            state_d = lut_nxt;
            out_d   = lut_out;
            dwell_d = lut_dwell;
            cnt_d   = cnt_q + CNT_W'(1);
        end else if (tick) begin
            dwell_d = dwell_q - DWELL_W'(1);
        end
        if (bkpt_event) begin
            hit_d = 1'b1;
        end else if (regs_if.bkpt_clr_i) begin
            hit_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= '0;
            out_q   <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
        end else if (cke_i) begin
            if (regs_if.softreset_i) begin
                state_q <= '0;
                out_q   <= '0;
                dwell_q <= '0;
                cnt_q   <= '0;
                hit_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                out_q   <= out_d;
                dwell_q <= dwell_d;
                cnt_q   <= cnt_d;
                hit_q   <= hit_d;
            end
        end
    end

    assign output_o            = out_q;
    assign regs_if.state_o     = state_q;
    assign regs_if.dwell_o     = dwell_q;
    assign regs_if.running_o   = (ctrl_q == RUN);
    assign regs_if.bkpt_hit_o  = hit_q;
    assign regs_if.trans_cnt_o = cnt_q;

endmodule
